// File: rtl/sipo_pkg.sv
// ----------------------------------------------------------------------------
// sipo_pkg
//   Shared definitions for the sipo_rx serial receiver: receiver FSM state
//   encoding and the bit-order selector values for the SHIFT_DIR parameter.
// ----------------------------------------------------------------------------
package sipo_pkg;

  // Receiver FSM: SHIFT collects data bits, PARITY collects the trailing
  // parity bit (only reachable when parity is compiled in).
  typedef enum logic [0:0] {
    ST_SHIFT  = 1'b0,
    ST_PARITY = 1'b1
  } sipo_state_e;

  // SHIFT_DIR values
  localparam int DIR_LSB_FIRST = 0;  // first bit received lands in word[0]
  localparam int DIR_MSB_FIRST = 1;  // first bit received lands in word[SIZE-1]

endpackage : sipo_pkg

// File: rtl/sipo_hold_reg.sv
// ----------------------------------------------------------------------------
// sipo_hold_reg
//   One-word valid/ready holding register. A completed word is loaded when the
//   register is free (empty, or being accepted on the same edge); otherwise the
//   word is dropped and a one-cycle overrun pulse is raised.
// Ports
//   clk        in   1      clock
//   reset_n    in   1      asynchronous active-low reset
//   i_load     in   1      a new word is offered this cycle
//   i_data     in   WIDTH  word offered with i_load
//   i_ready    in   1      downstream accepts the held word when o_valid=1
//   o_data     out  WIDTH  held word
//   o_valid    out  1      o_data holds an unaccepted word
//   o_overrun  out  1      one-cycle pulse: offered word dropped (register full)
// ----------------------------------------------------------------------------
module sipo_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_free;

  // Free when empty or when the current word is being accepted this edge, so a
  // new word can replace an accepted one without a bubble.
  assign w_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_load && !w_free;
      if (i_load && w_free) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule : sipo_hold_reg

// File: rtl/sipo_rx.sv
// ----------------------------------------------------------------------------
// sipo_rx
//   Serial-in parallel-out receiver for the bit-serial PISO link. One bit is
//   sampled per enable beat; SIZE bits form a word that is presented through a
//   one-word valid/ready holding register with overrun detection.
// Configuration
//   SIPO_PARITY_EN  when defined, each word is followed by one parity bit and
//                   the parity_err output is present (sense set by PARITY_ODD).
// Parameters
//   SIZE        word width in bits (>= 2)
//   SHIFT_DIR   DIR_LSB_FIRST (0) or DIR_MSB_FIRST (1)
//   PARITY_ODD  0 even parity, 1 odd parity (used only with SIPO_PARITY_EN)
// Ports
//   clk         in   1     clock
//   reset_n     in   1     asynchronous active-low reset
//   enable      in   1     bit strobe
//   in          in   1     serial data bit
//   clear       in   1     synchronous abort of the partial word
//   ready       in   1     downstream accepts word when valid&ready
//   out         out  SIZE  received word
//   valid       out  1     out holds an unaccepted word
//   done        out  1     one-cycle pulse per completed word (kept or dropped)
//   busy        out  1     a partial word is in progress
//   overrun     out  1     one-cycle pulse: completed word dropped
//   parity_err  out  1     parity result of the word in out (SIPO_PARITY_EN only)
// ----------------------------------------------------------------------------
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int SHIFT_DIR  = DIR_LSB_FIRST,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            in,
  input  logic            clear,
  input  logic            ready,
  output logic [SIZE-1:0] out,
  output logic            valid,
  output logic            done,
  output logic            busy,
  output logic            overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int            CW        = $clog2(SIZE);
  localparam logic [CW-1:0] LAST      = CW'(SIZE - 1);
  localparam bit            LSB_FIRST = (SHIFT_DIR == DIR_LSB_FIRST);
  localparam logic [0:0]    S_SHIFT   = ST_SHIFT;
`ifdef SIPO_PARITY_EN
  localparam logic [0:0]    S_PARITY  = ST_PARITY;
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);
  localparam int            PW        = SIZE + 1;  // parity flag travels with the word
`else
  localparam int            PW        = SIZE;
`endif

  logic [CW-1:0]   r_cnt;
  logic [0:0]      r_state;
  logic [SIZE-1:0] r_shreg;
  logic            r_done;

  logic [CW-1:0]   w_idx;
  logic            w_last_bit;
  logic [SIZE-1:0] w_next_word;
  logic            w_complete;
  logic [PW-1:0]   w_payload;
  logic [PW-1:0]   w_hold_data;

  // Bits are written in place at their final position rather than shifted,
  // so both bit orders share the same datapath.
  assign w_idx      = LSB_FIRST ? r_cnt : (LAST - r_cnt);
  assign w_last_bit = (r_cnt == LAST);

  always_comb begin
    // NOTE: the default assignment first means every path drives w_next_word,
    // so no latch is inferred for the bits not being written.
    w_next_word        = r_shreg;
    w_next_word[w_idx] = in;
  end

`ifdef SIPO_PARITY_EN
  logic w_perr;
  // The word completes on the parity beat; the data bits are already in r_shreg.
  assign w_complete = enable && !clear && (r_state == S_PARITY);
  assign w_perr     = ((^r_shreg) ^ in) != ODD_BIT;
  assign w_payload  = {w_perr, r_shreg};
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
  // Without parity the word completes on its last data bit, bypassing r_shreg
  // so out is visible one clock after the last bit.
  assign w_complete = enable && !clear && w_last_bit;
  assign w_payload  = w_next_word;
`endif

  // NOTE: sequential state uses nonblocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_state <= S_SHIFT;
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (clear) begin
        // Abort the partial word; the holding register is left alone.
        r_cnt   <= '0;
        r_state <= S_SHIFT;
      end else if (enable) begin
`ifdef SIPO_PARITY_EN
        if (r_state == S_PARITY) begin
          r_state <= S_SHIFT;
        end else begin
          r_shreg <= w_next_word;
          if (w_last_bit) begin
            r_cnt   <= '0;
            r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`else
        r_shreg <= w_next_word;
        r_cnt   <= w_last_bit ? '0 : r_cnt + 1'b1;
`endif
      end
    end
  end

  sipo_hold_reg #(
    .WIDTH (PW)
  ) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_complete),
    .i_data    (w_payload),
    .i_ready   (ready),
    .o_data    (w_hold_data),
    .o_valid   (valid),
    .o_overrun (overrun)
  );

`ifdef SIPO_PARITY_EN
  assign {parity_err, out} = w_hold_data;
`else
  assign out = w_hold_data;
`endif

  assign done = r_done;
  assign busy = (r_cnt != '0) || (r_state != S_SHIFT);

endmodule : sipo_rx
